// File: rtl/counter_dram_feeder.sv
// -----------------------------------------------------------------------------
// counter_dram_feeder
//
// Upstream stage of the byte transmitter in the counter-with-DRAM path.
// A free-running 8-bit sample counter is written on a prescaled tick into a
// small circular RAM. A four-state read FSM drains the RAM one byte at a time
// into the transmitter through a wr_en / tx_busy handshake. This decouples the
// sample rate from transmitter throughput and reports fill and overflow status.
//
// Configuration macro:
//   FEEDER_OVERWRITE_EN  defined   : a push into a full buffer overwrites the
//                                    oldest sample (both pointers advance).
//                        undefined : a push into a full buffer is dropped.
//                        In both cases the sticky overflow flag is set.
//
// Parameters:
//   DEPTH     RAM entries, power of two, 2..256
//   ADDR_W    log2(DEPTH)
//   TICK_DIV  clk_tx cycles per sample tick, >= 2
//
// Ports:
//   clk_tx     in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cnt_en     in   ticks produce samples while high
//   tx_busy    in   transmitter busy flag
//   data_out   out  byte presented to the transmitter (held until next ISSUE)
//   wr_en      out  one-cycle transmit strobe
//   count_out  out  current sample counter value
//   level      out  number of stored entries
//   empty      out  level == 0
//   full       out  level == DEPTH
//   overflow   out  sticky: a sample was lost or overwritten
//   state_out  out  read FSM state (debug)
// -----------------------------------------------------------------------------
module counter_dram_feeder #(
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int TICK_DIV = 1000
) (
   input  logic              clk_tx,
   input  logic              rst_n,
   input  logic              cnt_en,
   input  logic              tx_busy,
   output logic [7:0]        data_out,
   output logic              wr_en,
   output logic [7:0]        count_out,
   output logic [ADDR_W:0]   level,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic [1:0]        state_out
);

   localparam int                DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
   localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FETCH = 2'b01,
      S_ISSUE = 2'b10,
      S_WAIT  = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     level_q, level_d;
   logic                empty_q, full_q;
   logic                ovf_q, ovf_d;
   logic [7:0]          data_q, data_d;
   logic                wr_en_q, wr_en_d;
   logic                busy_seen_q, busy_seen_d;
   logic                low_prev_q, low_prev_d;

   logic [7:0]          mem [DEPTH];

   logic                tick, push, pop, accept, mem_we;

   // -------------------------------------------------------------------------
   // Prescaler, sample push and fill accounting
   // -------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      tick     = (div_q == DIV_LAST);
      push     = tick & cnt_en;
      pop      = (state_q == S_FETCH);
      // Capacity is judged on the pre-edge level; a same-cycle pop frees a slot.
      accept   = push & (~full_q | pop);

      div_d    = tick ? '0 : div_q + DIV_W'(1);
      cnt_d    = push ? cnt_q + 8'd1 : cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      mem_we   = 1'b0;

      if (pop) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end

      if (accept) begin
         mem_we   = 1'b1;
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end else if (push) begin
         ovf_d = 1'b1;
`ifdef FEEDER_OVERWRITE_EN
         // Full and no pop this cycle: overwrite the oldest entry. rd_ptr was
         // not advanced above, so moving both keeps level pinned at DEPTH.
         mem_we   = 1'b1;
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
`endif
      end

      unique case ({accept, pop})
         2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
         2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
         default: level_d = level_q;
      endcase
   end

   // -------------------------------------------------------------------------
   // Read FSM: next state and registered transmit outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      wr_en_d     = 1'b0;
      busy_seen_d = busy_seen_q;
      low_prev_d  = low_prev_q;

      unique case (state_q)
         S_IDLE: begin
            if (!empty_q && !tx_busy) state_d = S_FETCH;
         end
         S_FETCH: begin
            // The RAM read is registered straight into data_out, so the byte
            // and the strobe are both visible during ISSUE.
            data_d  = mem[rd_ptr_q];
            wr_en_d = 1'b1;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            busy_seen_d = tx_busy;
            low_prev_d  = ~tx_busy;
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            // Done once busy has risen and fallen, or when busy never rose and
            // has been low for two cycles running (ISSUE counts as the first).
            if (busy_seen_q ? !tx_busy : (low_prev_q && !tx_busy)) begin
               state_d = S_IDLE;
            end
            busy_seen_d = busy_seen_q | tx_busy;
            low_prev_d  = ~tx_busy;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement or process order.
   always_ff @(posedge clk_tx or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         ovf_q       <= 1'b0;
         data_q      <= '0;
         wr_en_q     <= 1'b0;
         busy_seen_q <= 1'b0;
         low_prev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         empty_q     <= (level_d == '0);
         full_q      <= (level_d == LEVEL_FULL);
         ovf_q       <= ovf_d;
         data_q      <= data_d;
         wr_en_q     <= wr_en_d;
         busy_seen_q <= busy_seen_d;
         low_prev_q  <= low_prev_d;
      end
   end

   // NOTE: the sample RAM has no reset; stale contents are unreachable because
   // the pointers and level are reset, and this lets it map onto RAM cells.
   // A same-edge write and read of one address returns the old byte.
   always_ff @(posedge clk_tx) begin
      if (mem_we) mem[wr_ptr_q] <= cnt_q;
   end

   assign data_out  = data_q;
   assign wr_en     = wr_en_q;
   assign count_out = cnt_q;
   assign level     = level_q;
   assign empty     = empty_q;
   assign full      = full_q;
   assign overflow  = ovf_q;
   assign state_out = state_q;

endmodule

// File: doc/counter_dram_feeder.md
# counter_dram_feeder

Upstream stage of the byte transmitter in the counter-with-DRAM path. An 8-bit free-running sample counter is written on a prescaled tick into a small circular 8-bit RAM. The stored values are drained one byte at a time into the transmitter through a `wr_en` / `tx_busy` handshake. The block decouples the sample rate from transmitter throughput and reports fill and overflow status.

## Interface
- `DEPTH`, 16: number of RAM entries; must be a power of two, 2..256.
- `ADDR_W`, 4: log2(`DEPTH`).
- `TICK_DIV`, 1000: `clk_tx` cycles per sample tick; minimum 2.
- `clk_tx`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cnt_en`, in, 1: when high, ticks produce samples; when low, the prescaler still runs but ticks are ignored.
- `tx_busy`, in, 1: transmitter busy flag.
- `data_out`, out, 8: byte presented to the transmitter's `data_in`.
- `wr_en`, out, 1: one-cycle transmit strobe.
- `count_out`, out, 8: current counter value.
- `level`, out, `ADDR_W`+1: number of entries stored.
- `empty`, out, 1: `level`==0.
- `full`, out, 1: `level`==`DEPTH`.
- `overflow`, out, 1: sticky flag; a sample was lost or overwritten; cleared only by reset.
- `state_out`, out, 2: read FSM state, for debug.

## Operation
- Prescaler:
  - `div_cnt` counts 0..`TICK_DIV`-1 and wraps.
  - `tick` is high for the single cycle in which `div_cnt`==`TICK_DIV`-1.
- Sample push:
  - A push occurs on `tick` && `cnt_en`.
  - The push writes the current `count_out` to RAM[`wr_ptr`], increments `wr_ptr` modulo `DEPTH`, and sets `count_out` to `count_out`+1.
  - `count_out` wraps 0xFF→0x00. The first sample after reset is 0x00.
- Push when full (capacity is decided from the pre-edge `level`):
  - If a pop occurs in the same cycle, the push is accepted normally.
  - Otherwise the behaviour is set by the macro (see Configuration).
  - `count_out` increments on every push event, whether the sample is accepted or not.
- Read FSM:
  - IDLE (00):
    - Go to FETCH when !`empty` && !`tx_busy`.
  - FETCH (01):
    - Synchronous RAM read of RAM[`rd_ptr`].
    - Pop: `rd_ptr`+1, and `level` decrements.
    - Go to ISSUE.
  - ISSUE (10):
    - Register the RAM output into `data_out`.
    - `wr_en`=1 for this cycle only.
    - Go to WAIT.
  - WAIT (11):
    - Track `busy_seen`.
    - Return to IDLE when `tx_busy` has risen and then fallen.
    - Also return to IDLE if `tx_busy` stays low for 2 consecutive cycles after ISSUE (transmitter accepted without asserting busy).
- `data_out` holds its value until the next ISSUE.
- `level` update per cycle: +1 on an accepted push without a pop; -1 on a pop without a push; unchanged when both occur or neither occurs.

## Timing
- Reset values: `count_out`=0x00, `data_out`=0x00, `wr_en`=0, `level`=0, `empty`=1, `full`=0, `overflow`=0, `state_out`=00. Both pointers and the prescaler are also 0.
- Reset takes effect immediately, mid-transfer included. `wr_en` drops without waiting for the clock edge. Buffered data is discarded.
- First tick occurs `TICK_DIV` cycles after reset release.
- Push-to-strobe latency, for a push at edge E into an empty buffer with `tx_busy` low:
  - `empty` falls after E.
  - FETCH is entered at E+1.
  - ISSUE is entered at E+2.
  - `data_out` is valid and `wr_en`=1 for the cycle following E+2.
- Back-to-back bytes are at least 4 cycles apart (IDLE→FETCH→ISSUE→WAIT), plus the transmitter's busy time.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `FEEDER_OVERWRITE_EN` defined:
  - A push into a full buffer with no same-cycle pop writes RAM[`wr_ptr`].
  - It advances both `wr_ptr` and `rd_ptr`, so the oldest sample is discarded.
  - `level` stays at `DEPTH`, and `overflow` is set.
- `FEEDER_OVERWRITE_EN` undefined:
  - The same push is dropped: RAM and pointers are unchanged, and `overflow` is set.
  - The buffer keeps the oldest `DEPTH` samples.

## Test plan
- Reset then idle, with `TICK_DIV`=4, `cnt_en`=1, `tx_busy` tied low.
  - Response: `wr_en` pulses carry `data_out` 0x00, 0x01, 0x02… in order.
  - Each pulse is exactly one cycle wide.
  - `level` never exceeds 1.
- Hold `tx_busy`=1 with `DEPTH`=16 and 20 ticks.
  - Response: `full`=1 after the 16th push, and `overflow`=1 at the 17th.
  - After `tx_busy` is released, the drained bytes are:
    - macro undefined: 0x00..0x0F;
    - macro defined: 0x04..0x13.
- Counter wrap with 258 ticks and a fast drain.
  - Response: bytes …0xFE, 0xFF, 0x00, 0x01, with no gap or duplicate.
- Simultaneous push and pop while full (force a tick in the FETCH cycle).
  - Response: `level` stays at 16, `overflow` stays 0, and no sample is lost.
- Handshake: `tx_busy` rises 1 cycle after `wr_en` and falls 10 cycles later.
  - Response: the next `wr_en` occurs no earlier than 3 cycles after `tx_busy` falls.
  - `state_out` sequence is 10→11→00→01→10.
- Assert `rst_n` low during WAIT with `level`=5.
  - Response: all outputs take reset values immediately.
  - After release, the first byte sent is 0x00.
